// File: rtl/mtm_tile_loader.sv
// Row-to-tile assembler feeding the matrix-transpose memory, ping-pong double buffered.
// Optional framing check on an in_last sideband: define MTM_TILE_LOADER_LAST_CHECK_EN.
module mtm_tile_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_MG     = 8,
    parameter int NUM_PE     = NUM_MG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_row [0:NUM_PE-1],
`ifdef MTM_TILE_LOADER_LAST_CHECK_EN
    input  logic                  in_last,
    output logic                  frame_err,
`endif
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_tile [0:NUM_MG-1][0:NUM_PE-1],
    output logic [1:0]            tiles_buffered
);

    localparam int CW = $clog2(NUM_MG);
    localparam logic [CW-1:0] LAST_ROW = CW'(NUM_MG - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} buf_state_t;

    buf_state_t            state_reg [0:1];
    logic                  wr_buf_reg;
    logic                  rd_buf_reg;
    logic [CW-1:0]         row_cnt_reg;
    logic [1:0]            tiles_buffered_reg;
    logic [DATA_WIDTH-1:0] mem_reg [0:1][0:NUM_MG-1][0:NUM_PE-1];

    logic accept;
    logic drain;
    logic last_row;
    logic early_last;
    logic complete;

    assign in_ready       = (state_reg[wr_buf_reg] != FULL);
    assign out_val        = (state_reg[rd_buf_reg] == FULL);
    assign tiles_buffered = tiles_buffered_reg;
    assign accept         = in_valid && in_ready;
    assign drain          = out_val && out_rdy;
    assign last_row       = (row_cnt_reg == LAST_ROW);
`ifdef MTM_TILE_LOADER_LAST_CHECK_EN
    assign early_last     = accept && in_last && !last_row;
`else
    assign early_last     = 1'b0;
`endif
    assign complete       = accept && last_row && !early_last;

    // Accept and drain never target the same buffer: one needs it FULL, the other not FULL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg[0]       <= EMPTY;
            state_reg[1]       <= EMPTY;
            wr_buf_reg         <= 1'b0;
            rd_buf_reg         <= 1'b0;
            row_cnt_reg        <= '0;
            tiles_buffered_reg <= 2'd0;
        end else begin
            if (drain) begin
                state_reg[rd_buf_reg] <= EMPTY;
                rd_buf_reg            <= ~rd_buf_reg;
            end
            if (accept) begin
                if (early_last) begin
                    state_reg[wr_buf_reg] <= EMPTY;
                    row_cnt_reg           <= '0;
                end else if (last_row) begin
                    state_reg[wr_buf_reg] <= FULL;
                    row_cnt_reg           <= '0;
                    wr_buf_reg            <= ~wr_buf_reg;
                end else begin
                    state_reg[wr_buf_reg] <= FILLING;
                    row_cnt_reg           <= row_cnt_reg + 1'b1;
                end
            end
            tiles_buffered_reg <= tiles_buffered_reg + {1'b0, complete} - {1'b0, drain};
        end
    end

`ifdef MTM_TILE_LOADER_LAST_CHECK_EN
    logic frame_err_reg;

    // Flags both an early in_last and a missing one on the final row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= accept && (in_last != last_row);
        end
    end

    assign frame_err = frame_err_reg;
`endif

    // Tile storage is never cleared; contents only matter once a buffer is FULL.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int p = 0; p < NUM_PE; p++) begin
                mem_reg[wr_buf_reg][row_cnt_reg][p] <= in_row[p];
            end
        end
    end

    genvar gi, gp;
    generate
        for (gi = 0; gi < NUM_MG; gi++) begin : g_row
            for (gp = 0; gp < NUM_PE; gp++) begin : g_col
                assign out_tile[gi][gp] = mem_reg[rd_buf_reg][gi][gp];
            end
        end
    endgenerate

endmodule
